// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch-request FSM and the IF/ID
// pipeline register. An instruction accepted in cycle N is visible on
// ins_out/valid_out in cycle N+1. Redirects take priority over stall and
// memory return; a misaligned redirect parks the stage in FAULT until reset.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000000000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [63:0] pc_out,
  output logic        valid_out,
  output logic        fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc;
  logic        redir_bad;
  logic        hold;
  logic        accept;

  assign redir_bad = redirect & (|redirect_pc[1:0]);
  // IF/ID is occupied and decode is not taking it this cycle
  assign hold      = valid_out & stall;
  // a returned word is only taken while requesting and nothing overrides it
  assign accept    = (state == S_FETCH) & imem_ready & ~redirect & ~hold;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; FAULT is absorbing, redirects win over everything else
  always_comb begin
    state_nxt = state;
    if (state != S_FAULT) begin
      if (redir_bad)     state_nxt = S_FAULT;
      else if (redirect) state_nxt = S_FETCH;
      else begin
        case (state)
          S_IDLE:  state_nxt = S_FETCH;
          S_FETCH: state_nxt = hold ? S_HOLD : S_FETCH;
          S_HOLD:  state_nxt = hold ? S_HOLD : S_FETCH;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Output logic: only FETCH issues requests
  always_comb begin
    imem_req = (state == S_FETCH);
  end

  // PC, IF/ID register, fault flag and fetch counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= RESET_PC;
      ins_out   <= '0;
      pc_out    <= '0;
      valid_out <= 1'b0;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else if (state != S_FAULT) begin
      if (redirect) begin
        // same-cycle imem_rdata is dropped; the bad target is never loaded
        valid_out <= 1'b0;
        if (redir_bad) fault <= 1'b1;
        else           pc    <= redirect_pc;
      end else if (accept) begin
        ins_out   <= imem_rdata;
        pc_out    <= pc;
        valid_out <= 1'b1;
        pc        <= pc + 64'd4;
        fetch_cnt <= fetch_cnt + 32'd1;
      end else if (valid_out && !stall) begin
        // decode consumed the instruction and nothing replaced it: bubble
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each expected fetch is pushed to a
// scoreboard when the accepting cycle is driven; a monitor pops and compares
// whenever a new instruction appears on the IF/ID outputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins_out;
  logic [63:0] pc_out;
  logic        valid_out;
  logic        fault;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_pc;
  logic [63:0] q_pc[$];
  logic [31:0] q_ins[$];

  fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ins_out(ins_out),
    .pc_out(pc_out), .valid_out(valid_out), .fault(fault), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic rd, input logic [63:0] rpc,
                     input logic rdy, input logic [31:0] d);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ready = rdy; imem_rdata = d;
    @(posedge clk); #1;
  endtask

  // one cycle in which the bench expects the returned word to be accepted
  task automatic fetch_ok(input logic [31:0] d);
    q_pc.push_back(exp_pc);
    q_ins.push_back(d);
    cyc(1'b0, 1'b0, 64'h0, 1'b1, d);
    exp_pc = exp_pc + 64'd4;
  endtask

  // Scoreboard monitor: a live instruction that was not held over this edge is new
  always @(posedge clk) begin
    logic was_hold;
    was_hold = reset && valid_out && stall && !redirect;
    #1;
    if (reset && valid_out && !was_hold) begin
      if (q_pc.size() == 0) begin
        chk("sb_unexpected_pc", pc_out, 64'hx);
      end else begin
        chk("sb_pc", pc_out, q_pc.pop_front());
        chk("sb_ins", {32'h0, ins_out}, {32'h0, q_ins.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0; exp_pc = 64'h0;

    // reset state
    cyc(1'b0, 1'b1, 64'h40, 1'b1, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 64'h0, 1'b1, 32'hDEADBEEF);
    chk("rst_valid0", {63'h0, valid_out}, 64'h0);
    chk("rst_ins", {32'h0, ins_out}, 64'h0);
    chk("rst_pc_out", pc_out, 64'h0);
    chk("rst_fault", {63'h0, fault}, 64'h0);
    chk("rst_cnt", {32'h0, fetch_cnt}, 64'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);

    // release: IDLE -> FETCH
    reset = 1'b1;
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 32'h00A00093);
    chk("rel_req", {63'h0, imem_req}, 64'h1);
    chk("rel_addr", imem_addr, 64'h0);

    // back-to-back fetches 0,4,8
    fetch_ok(32'h00A00093);
    fetch_ok(32'h00A00093);
    fetch_ok(32'h00A00093);
    chk("seq_cnt", {32'h0, fetch_cnt}, 64'd3);
    chk("seq_addr", imem_addr, 64'd12);

    // stall for 3 cycles holding pc_out=8
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 64'h0, 1'b1, 32'h11111111 + i);
      chk("hold_pc", pc_out, 64'd8);
      chk("hold_ins", {32'h0, ins_out}, {32'h0, 32'h00A00093});
      chk("hold_req", {63'h0, imem_req}, 64'h0);
      chk("hold_valid", {63'h0, valid_out}, 64'h1);
    end
    // stall drops: held instruction consumed, ready ignored while not requesting
    cyc(1'b0, 1'b0, 64'h0, 1'b1, 32'h22222222);
    chk("unhold_valid", {63'h0, valid_out}, 64'h0);
    chk("unhold_req", {63'h0, imem_req}, 64'h1);
    chk("unhold_cnt", {32'h0, fetch_cnt}, 64'd3);
    fetch_ok(32'h00C00113);
    chk("after_hold_pc", pc_out, 64'd12);

    // aligned redirect with imem_ready in the same cycle
    cyc(1'b0, 1'b1, 64'h100, 1'b1, 32'h33333333);
    chk("redir_valid", {63'h0, valid_out}, 64'h0);
    chk("redir_addr", imem_addr, 64'h100);
    chk("redir_cnt", {32'h0, fetch_cnt}, 64'd4);
    exp_pc = 64'h100;
    fetch_ok(32'h00100193);
    fetch_ok(32'h00200213);

    // imem_ready low for 4 cycles: bubbles, address and count stable
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 64'h0, 1'b0, 32'h44444444);
      chk("bub_valid", {63'h0, valid_out}, 64'h0);
      chk("bub_addr", imem_addr, 64'h108);
      chk("bub_cnt", {32'h0, fetch_cnt}, 64'd6);
    end
    fetch_ok(32'h00300293);

    // wrap across the top of the address space
    cyc(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0, 32'h0);
    exp_pc = 64'hFFFFFFFFFFFFFFFC;
    fetch_ok(32'h00400313);
    fetch_ok(32'h00500393);
    chk("wrap_pc_out", pc_out, 64'h0);
    chk("wrap_addr", imem_addr, 64'h4);

    // misaligned redirect -> FAULT, later redirects ignored
    cyc(1'b0, 1'b1, 64'h102, 1'b1, 32'h55555555);
    chk("flt_fault", {63'h0, fault}, 64'h1);
    chk("flt_valid", {63'h0, valid_out}, 64'h0);
    chk("flt_req", {63'h0, imem_req}, 64'h0);
    cyc(1'b0, 1'b1, 64'h200, 1'b1, 32'h66666666);
    chk("flt_ign_req", {63'h0, imem_req}, 64'h0);
    chk("flt_ign_addr", imem_addr, 64'h4);
    chk("flt_ign_fault", {63'h0, fault}, 64'h1);
    chk("flt_ign_cnt", {32'h0, fetch_cnt}, 64'd9);

    // reset from FAULT overrides a concurrent redirect
    reset = 1'b0;
    cyc(1'b1, 1'b1, 64'h300, 1'b1, 32'h77777777);
    chk("rst2_fault", {63'h0, fault}, 64'h0);
    chk("rst2_cnt", {32'h0, fetch_cnt}, 64'h0);
    chk("rst2_pc_out", pc_out, 64'h0);
    chk("rst2_addr", imem_addr, 64'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 64'h0, 1'b0, 32'h0);
    chk("rst2_req", {63'h0, imem_req}, 64'h1);

    chk("sb_drained", 64'(q_pc.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000000000000000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port stall  input  1  decode/hazard stall; the output register must hold.
REQ-005 SHALL have port redirect  input  1  taken branch or flush from a later stage.
REQ-006 SHALL have port redirect_pc  input  64  branch target PC.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  output  64  fetch address; equals current PC.
REQ-009 SHALL have port imem_ready  input  1  instruction memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port ins_out  output  32  IF/ID instruction, consumed by decode and ImmGen.
REQ-012 SHALL have port pc_out  output  64  PC of ins_out.
REQ-013 SHALL have port valid_out  output  1  ins_out/pc_out hold a live instruction.
REQ-014 SHALL have port fault  output  1  sticky misaligned-redirect flag.
REQ-015 SHALL have port fetch_cnt  output  32  count of instructions loaded into IF/ID.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, HOLD, FAULT; IDLE is entered on reset and goes to FETCH unconditionally on the next cycle.
REQ-017 In FETCH: imem_req=1 and imem_addr=PC; in IDLE, HOLD and FAULT: imem_req=0.
REQ-018 Accept (FETCH, imem_ready=1, redirect=0, and not (valid_out=1 and stall=1)) SHALL load ins_out<=imem_rdata, pc_out<=PC, valid_out<=1, PC<=PC+4, and fetch_cnt<=fetch_cnt+1.
REQ-019 Latency: an instruction returned in cycle N SHALL appear on ins_out/valid_out in cycle N+1.
REQ-020 PC+4 SHALL wrap modulo 2^64 (64'hFFFFFFFFFFFFFFFC -> 0); fetch_cnt SHALL wrap modulo 2^32.
REQ-021 valid_out=1 with stall=1 SHALL hold ins_out, pc_out, valid_out and PC unchanged, and SHALL move the FSM to HOLD (imem_req=0 from the next cycle).
REQ-022 HOLD SHALL return to FETCH in the cycle after stall=0; the held instruction counts as consumed in the first cycle stall=0.
REQ-023 Consume with no accept (valid_out=1, stall=0, no accept this cycle) SHALL set valid_out<=0 (bubble); ins_out/pc_out may keep stale values.
REQ-024 Aligned redirect (redirect=1, redirect_pc[1:0]=0) SHALL have priority over stall and imem_ready: PC<=redirect_pc, valid_out<=0, FSM<=FETCH, and the same-cycle imem_rdata is discarded (fetch_cnt unchanged).
REQ-025 Misaligned redirect (redirect=1, redirect_pc[1:0]!=0) SHALL set fault<=1, valid_out<=0, FSM<=FAULT; FAULT SHALL be left only by reset.
REQ-026 redirect while in FAULT SHALL be ignored.
REQ-027 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-028 With reset=0 sampled on a rising edge: PC<=RESET_PC, FSM<=IDLE, ins_out<=0, pc_out<=0, valid_out<=0, fault<=0, fetch_cnt<=0.
REQ-029 Reset SHALL override redirect, stall and imem_ready in the same cycle, including mid-HOLD and in FAULT.

Verification
REQ-030 Reset release, imem_ready=1 always, rdata=32'h00A00093 -> imem_req=1 from cycle 2 at addr 0; valid_out=1 with pc_out=0,4,8 on consecutive cycles; fetch_cnt=3.
REQ-031 Stall high for 3 cycles with pc_out=8 -> ins_out/pc_out frozen, imem_req=0 during HOLD; after stall drops, the next valid pc_out=12 and no instruction is duplicated or lost.
REQ-032 redirect=1, redirect_pc=64'h100, imem_ready=1 in the same cycle -> valid_out=0 the next cycle, imem_addr=64'h100, and the next valid pc_out=64'h100.
REQ-033 redirect_pc=64'h102 -> fault=1, imem_req=0 thereafter, and later redirects are ignored until reset=0 clears all outputs.
REQ-034 Redirect to 64'hFFFFFFFFFFFFFFFC -> pc_out sequence ...FC then 0.
REQ-035 imem_ready held 0 for 4 cycles -> valid_out=0 bubbles; imem_addr stable; fetch_cnt unchanged.
